pl_fp_scoreboard: RTL and testbench
===================================

# pl_fp_scoreboard

Parametrised floating-point hazard scoreboard for the ID stage. It tracks in-flight FPR destinations in an N-stage pipelined FPU and in a pool of long-latency div/sqrt slots. From that state it produces the FP stall, the operand forward selects and the write-port arbitration. It replaces hard-wired per-stage compare chains (fixed e1/e2/e3 tags) with a depth-generic structure, and adds multi-outstanding long-op tracking and write-port conflict handling.

## Interface
Parameters:
- NSTAGE, 3: pipelined FPU depth (≥2); the result is forwardable only from the last stage.
- NLONG, 2: concurrent div/sqrt slots (≥1).
- LONG_LAT, 12: div/sqrt latency in cycles from issue to result (≥2).

Ports (all synchronous to clk):
- clk  in  1  clock.
- clrn  in  1  reset; synchronous, active-low.
- id_v  in  1  valid instruction in ID.
- id_fs_use, id_ft_use  in  1  instruction reads fs / ft.
- fs, ft, fd  in  5  FPR source and destination numbers.
- id_pipe  in  1  instruction is a pipelined FP op (fadd/fsub/fmul) writing fd.
- id_long  in  1  instruction is fdiv/fsqrt writing fd.
- flush  in  1  squash the ID instruction and the stage-1 entry (ecancel/trap).
- stall_ext  in  1  non-FP stall from elsewhere; freezes ID and the FP pipe.
- stall  out  1  FP-caused stall of ID (combinational).
- fwda, fwdb  out  2  operand source: 0 = register file, 1 = last pipe stage, 2 = long completion.
- wr_en  out  1  FPR write this cycle.
- wr_rd  out  5  FPR write address.
- wr_sel  out  1  write source: 0 = pipe, 1 = long slot.
- long_busy  out  1  any long slot occupied.

## Operation
- **Pipe shadow.** NSTAGE entries of {v, rd}.
  - issue_p = id_v & id_pipe & ~stall & ~stall_ext & ~flush.
  - Each cycle without stall_ext: entry[0] ← {issue_p, fd} and entry[k] ← entry[k-1].
  - Under stall_ext, all entries hold.
- **Long slots.** NLONG entries of {v, rd, cnt}.
  - issue_l = id_v & id_long & ~stall & ~stall_ext & ~flush.
  - issue_l loads the lowest-index free slot with cnt = LONG_LAT-1.
  - cnt decrements every cycle regardless of stall_ext.
  - A slot at cnt = 0 is completing.
- **Write port (single).**
  - A valid last pipe stage with ~stall_ext wins.
  - A completing long slot that loses holds at cnt = 0 until the port is free.
  - If several slots complete at once, the lowest index wins; the others hold.
  - wr_en/wr_rd/wr_sel reflect the winner.
- **Stall** asserts when id_v and any of:
  - RAW on a pipe entry in stage 0..NSTAGE-2 whose rd equals a used source.
  - RAW on a long slot with cnt > 0, or on a completing slot that is not the write winner.
  - id_long with all NLONG slots valid and none being freed this cycle.
  - WAW check (see Configuration).
- **Forwarding.**
  - fwda = 1 if the last stage is valid with rd == fs.
  - Otherwise fwda = 2 if the winning long slot has rd == fs.
  - Otherwise fwda = 0. fwdb is the same with ft.
  - Forwards are gated by id_fs_use / id_ft_use.
  - Register FPR 0 is a real register: there is no rd ≠ 0 exclusion.
- **flush.**
  - Suppresses issue this cycle and invalidates entry[0] before the shift.
  - Long slots are never flushed: an issued div/sqrt always completes.

## Timing
- Reset (clrn = 0 at posedge): all pipe v = 0 and all slot v = 0, cnt = 0.
  - Outputs after reset: stall = 0, fwda = fwdb = 0, wr_en = 0, wr_rd = 0, wr_sel = 0, long_busy = 0.
- Reset mid-operation discards all in-flight tags; no write follows.
- A pipe op issued at cycle t writes at t+NSTAGE, absent stall_ext.
- A long op issued at t writes at t+LONG_LAT, absent a port conflict.
- stall is combinational from current state and ID inputs. All state updates on posedge clk.
- A slot freed by completion at t is reusable by an issue at t; the slot re-arms at t+1.

## Configuration
- SCOREBOARD_WAW_EN defined: stall an id_pipe instruction whose fd matches a valid long slot rd. This prevents an older div result overwriting a newer value.
- SCOREBOARD_WAW_EN undefined: no WAW check; the write order is the completion order.

## Test plan
- **Reset/idle:** clrn = 0 for 2 cycles, then idle. Outputs stay at reset values; no stall for fadd f1,f2,f3.
- **RAW pipe (NSTAGE = 3):** fadd f4 at t, then fmul using f4 at t+1. stall = 1 at t+1 and t+2, released at t+3 with fwda = 1; wr_en, wr_rd = 4 at t+3.
- **Long pool full (NLONG = 2, LONG_LAT = 12):**
  - fdiv f5 at t and fsqrt f6 at t+1, then fdiv f7 at t+2.
  - stall is held until t+12; f7 issues at t+12, and the f5 write at t+12 has wr_sel = 1.
- **Port conflict:**
  - Arrange a pipe last stage valid in the same cycle as a long cnt = 0.
  - The pipe writes first; the long write follows the next cycle with cnt held.
  - A dependent of the long op stays stalled one extra cycle.
- **Flush:** fadd f8 issued, then flush the next cycle. The entry is dropped; no write to f8 occurs.
- **WAW (SCOREBOARD_WAW_EN):**
  - fdiv f9, then fadd f9.
  - With the macro: fadd stalls until the div writes.
  - Without the macro: fadd issues at once.

Source files
------------

// File: rtl/pl_fp_scoreboard.sv
// pl_fp_scoreboard: floating-point hazard scoreboard for the ID stage.
// It tracks FPR destinations in flight in an NSTAGE-deep pipelined FPU and
// in NLONG div/sqrt slots. From that state it produces the FP stall, the
// operand forward selects and the single write-port arbitration.
// Optional feature: define SCOREBOARD_WAW_EN to stall a pipelined op whose fd
// is still pending in a long slot, so an older div/sqrt result can never
// overwrite a newer value.
module pl_fp_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int NLONG    = 2,
  parameter int LONG_LAT = 12
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       id_v,
  input  logic       id_fs_use,
  input  logic       id_ft_use,
  input  logic [4:0] fs,
  input  logic [4:0] ft,
  input  logic [4:0] fd,
  input  logic       id_pipe,
  input  logic       id_long,
  input  logic       flush,
  input  logic       stall_ext,
  output logic       stall,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       wr_en,
  output logic [4:0] wr_rd,
  output logic       wr_sel,
  output logic       long_busy
);

  localparam int CW = $clog2(LONG_LAT);

  // Pipe shadow: one {v, rd} per FPU stage; the last stage writes back.
  logic [NSTAGE-1:0] pv_q, pv_d;
  logic [4:0]        prd_q [NSTAGE];
  logic [4:0]        prd_d [NSTAGE];

  // Long slots: {v, rd, cnt}; cnt = 0 means the result is ready.
  logic [NLONG-1:0]  lv_q, lv_d;
  logic [4:0]        lrd_q [NLONG];
  logic [4:0]        lrd_d [NLONG];
  logic [CW-1:0]     lcnt_q [NLONG];
  logic [CW-1:0]     lcnt_d [NLONG];

  logic              pipe_wr;
  logic [NLONG-1:0]  lcomp, lwin, lfree, lalloc, long_hit;
  logic              long_win_any;
  logic [4:0]        win_rd;
  logic [NSTAGE-2:0] pipe_hit;
  logic              waw_stall;
  logic              issue_p, issue_l;

  // The pipe only writes when its last stage is valid and not frozen.
  assign pipe_wr      = pv_q[NSTAGE-1] & ~stall_ext;
  assign long_win_any = |lwin;

  genvar gi;
  generate
    for (gi = 0; gi < NLONG; gi++) begin : g_slot
      assign lcomp[gi]    = lv_q[gi] & (lcnt_q[gi] == '0);
      // A slot written back this cycle can be re-armed by this cycle's issue.
      assign lfree[gi]    = ~lv_q[gi] | lwin[gi];
      // Only the slot that actually owns the write port this cycle can be
      // forwarded; any other valid slot is still a hazard.
      assign long_hit[gi] = lv_q[gi] & ~lwin[gi] &
                            ((id_fs_use & (lrd_q[gi] == fs)) |
                             (id_ft_use & (lrd_q[gi] == ft)));
    end
    // Stages before the last have no forward path, so a match stalls.
    for (gi = 0; gi < NSTAGE - 1; gi++) begin : g_stage
      assign pipe_hit[gi] = pv_q[gi] &
                            ((id_fs_use & (prd_q[gi] == fs)) |
                             (id_ft_use & (prd_q[gi] == ft)));
    end
  endgenerate

`ifdef SCOREBOARD_WAW_EN
  logic [NLONG-1:0] waw_hit;
  generate
    for (gi = 0; gi < NLONG; gi++) begin : g_waw
      assign waw_hit[gi] = lv_q[gi] & ~lwin[gi] & (lrd_q[gi] == fd);
    end
  endgenerate
  assign waw_stall = id_pipe & (|waw_hit);
`else
  assign waw_stall = 1'b0;
`endif

  // Write-port winner among long slots: the lowest completing index, and only when the pipe is not writing.
  always_comb begin
    lwin   = '0;
    win_rd = '0;
    for (int i = NLONG - 1; i >= 0; i--) begin
      if (lcomp[i] && !pipe_wr) begin
        lwin    = '0;
        lwin[i] = 1'b1;
        win_rd  = lrd_q[i];
      end
    end
  end

  // Allocation target for a new long op: the lowest free (or freeing) slot.
  always_comb begin
    lalloc = '0;
    for (int i = NLONG - 1; i >= 0; i--) begin
      if (lfree[i]) begin
        lalloc    = '0;
        lalloc[i] = 1'b1;
      end
    end
  end

  assign stall = id_v & ((|pipe_hit) | (|long_hit) |
                         (id_long & (&lv_q) & ~long_win_any) | waw_stall);

  assign issue_p = id_v & id_pipe & ~stall & ~stall_ext & ~flush;
  assign issue_l = id_v & id_long & ~stall & ~stall_ext & ~flush;

  // Write port and forward selects, driven from the arbitration result.
  always_comb begin
    wr_en     = pipe_wr | long_win_any;
    wr_sel    = ~pipe_wr & long_win_any;
    wr_rd     = '0;
    if (pipe_wr) begin
      wr_rd = prd_q[NSTAGE-1];
    end else if (long_win_any) begin
      wr_rd = win_rd;
    end
    fwda = 2'd0;
    if (id_fs_use && pv_q[NSTAGE-1] && (prd_q[NSTAGE-1] == fs)) begin
      fwda = 2'd1;
    end else if (id_fs_use && long_win_any && (win_rd == fs)) begin
      fwda = 2'd2;
    end
    fwdb = 2'd0;
    if (id_ft_use && pv_q[NSTAGE-1] && (prd_q[NSTAGE-1] == ft)) begin
      fwdb = 2'd1;
    end else if (id_ft_use && long_win_any && (win_rd == ft)) begin
      fwdb = 2'd2;
    end
    long_busy = |lv_q;
  end

  // Pipe shadow advance; flush kills the stage-0 entry before it moves on.
  always_comb begin
    pv_d  = pv_q;
    prd_d = prd_q;
    if (!stall_ext) begin
      pv_d[0]  = issue_p;
      prd_d[0] = fd;
      for (int k = 1; k < NSTAGE; k++) begin
        pv_d[k]  = (k == 1) ? (pv_q[0] & ~flush) : pv_q[k-1];
        prd_d[k] = prd_q[k-1];
      end
    end else if (flush) begin
      pv_d[0] = 1'b0;
    end
  end

  // Long slots count down regardless of stall_ext, hold at 0 until written, then re-arm on issue.
  always_comb begin
    lv_d   = lv_q;
    lrd_d  = lrd_q;
    lcnt_d = lcnt_q;
    for (int i = 0; i < NLONG; i++) begin
      if (lwin[i]) begin
        lv_d[i] = 1'b0;
      end else if (lcnt_q[i] != '0) begin
        lcnt_d[i] = lcnt_q[i] - 1'b1;
      end
      if (issue_l && lalloc[i]) begin
        lv_d[i]   = 1'b1;
        lrd_d[i]  = fd;
        lcnt_d[i] = CW'(LONG_LAT - 1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      pv_q <= '0;
      lv_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        prd_q[k] <= '0;
      end
      for (int i = 0; i < NLONG; i++) begin
        lrd_q[i]  <= '0;
        lcnt_q[i] <= '0;
      end
    end else begin
      pv_q   <= pv_d;
      prd_q  <= prd_d;
      lv_q   <= lv_d;
      lrd_q  <= lrd_d;
      lcnt_q <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_pl_fp_scoreboard.sv
// tb_pl_fp_scoreboard: table vectors, directed multi-cycle sequences and
// randomized traffic checked against a time-based reference model.
// Follows SCOREBOARD_WAW_EN the same way as the design.
`timescale 1ns/1ps
module tb_pl_fp_scoreboard;
  localparam int NS = 3;
  localparam int NL = 2;
  localparam int LL = 12;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic id_v = 1'b0, id_fs_use = 1'b0, id_ft_use = 1'b0;
  logic [4:0] fs = '0, ft = '0, fd = '0;
  logic id_pipe = 1'b0, id_long = 1'b0, flush = 1'b0, stall_ext = 1'b0;
  logic stall, wr_en, wr_sel, long_busy;
  logic [1:0] fwda, fwdb;
  logic [4:0] wr_rd;

  always #5 clk = ~clk;

  pl_fp_scoreboard #(.NSTAGE(NS), .NLONG(NL), .LONG_LAT(LL)) dut (
    .clk(clk), .clrn(clrn), .id_v(id_v), .id_fs_use(id_fs_use),
    .id_ft_use(id_ft_use), .fs(fs), .ft(ft), .fd(fd), .id_pipe(id_pipe),
    .id_long(id_long), .flush(flush), .stall_ext(stall_ext), .stall(stall),
    .fwda(fwda), .fwdb(fwdb), .wr_en(wr_en), .wr_rd(wr_rd), .wr_sel(wr_sel),
    .long_busy(long_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pipe ops carry their age (cycles advanced since issue),
  // long ops carry the absolute cycle at which their result is ready.
  typedef struct { int rd; int age; } pent_t;
  pent_t pq[$];
  bit l_busy[NL];
  int l_rd[NL];
  int l_due[NL];
  bit m_pipe_wr;
  int m_win;

  logic e_stall, e_wr_en, e_wr_sel, e_busy;
  logic [1:0] e_fwda, e_fwdb;
  logic [4:0] e_wr_rd;
  logic a_stall, a_wr_en, a_wr_sel, a_busy;
  logic [1:0] a_fwda, a_fwdb;
  logic [4:0] a_wr_rd;

  typedef struct {
    logic v, fsu, ftu; logic [4:0] s, t, d; logic p, l, fl, sx;
    logic e_stall; logic [1:0] e_fwda, e_fwdb; logic e_wr_en; logic [4:0] e_wr_rd;
    logic e_wr_sel, e_busy;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit src_hit(input int rd);
    return (id_fs_use && rd == int'(fs)) || (id_ft_use && rd == int'(ft));
  endfunction

  task automatic model_eval();
    bit last_v = 0;
    int last_rd = 0;
    bit hit = 0;
    bit all_busy = 1;
    foreach (pq[i]) if (pq[i].age == NS) begin last_v = 1; last_rd = pq[i].rd; end
    m_pipe_wr = last_v && !stall_ext;
    m_win = -1;
    if (!m_pipe_wr)
      for (int s = 0; s < NL; s++)
        if (l_busy[s] && cyc >= l_due[s] && m_win < 0) m_win = s;
    foreach (pq[i]) if (pq[i].age < NS && src_hit(pq[i].rd)) hit = 1;
    for (int s = 0; s < NL; s++) begin
      if (l_busy[s] && s != m_win && src_hit(l_rd[s])) hit = 1;
      if (!l_busy[s]) all_busy = 0;
`ifdef SCOREBOARD_WAW_EN
      if (id_pipe && l_busy[s] && s != m_win && l_rd[s] == int'(fd)) hit = 1;
`endif
    end
    if (id_long && all_busy && m_win < 0) hit = 1;
    e_stall  = id_v && hit;
    e_wr_en  = m_pipe_wr || m_win >= 0;
    e_wr_sel = !m_pipe_wr && m_win >= 0;
    e_wr_rd  = 5'(m_pipe_wr ? last_rd : (m_win >= 0 ? l_rd[m_win] : 0));
    e_fwda = 2'd0;
    if (id_fs_use && last_v && last_rd == int'(fs)) e_fwda = 2'd1;
    else if (id_fs_use && m_win >= 0 && l_rd[m_win] == int'(fs)) e_fwda = 2'd2;
    e_fwdb = 2'd0;
    if (id_ft_use && last_v && last_rd == int'(ft)) e_fwdb = 2'd1;
    else if (id_ft_use && m_win >= 0 && l_rd[m_win] == int'(ft)) e_fwdb = 2'd2;
    e_busy = 1'b0;
    for (int s = 0; s < NL; s++) if (l_busy[s]) e_busy = 1'b1;
  endtask

  task automatic model_update();
    pent_t nq[$];
    bit ip, il, done;
    if (!clrn) begin
      pq.delete();
      for (int s = 0; s < NL; s++) l_busy[s] = 0;
      cyc++;
      return;
    end
    ip = id_v && id_pipe && !e_stall && !stall_ext && !flush;
    il = id_v && id_long && !e_stall && !stall_ext && !flush;
    if (!stall_ext) begin
      foreach (pq[i])
        if (pq[i].age != NS && !(flush && pq[i].age == 1))
          nq.push_back('{pq[i].rd, pq[i].age + 1});
      if (ip) nq.push_back('{int'(fd), 1});
      pq = nq;
    end else if (flush) begin
      foreach (pq[i]) if (pq[i].age != 1) nq.push_back(pq[i]);
      pq = nq;
    end
    if (m_win >= 0) l_busy[m_win] = 0;
    if (il) begin
      done = 0;
      for (int s = 0; s < NL; s++)
        if (!l_busy[s] && !done) begin
          l_busy[s] = 1; l_rd[s] = int'(fd); l_due[s] = cyc + LL; done = 1;
        end
    end
    cyc++;
  endtask

  // One clock: settle, compare against the model, advance to next negedge.
  task automatic step();
    #1;
    model_eval();
    a_stall = stall; a_fwda = fwda; a_fwdb = fwdb; a_wr_en = wr_en;
    a_wr_rd = wr_rd; a_wr_sel = wr_sel; a_busy = long_busy;
    chk("model_stall", a_stall, e_stall);
    chk("model_fwda", a_fwda, e_fwda);
    chk("model_fwdb", a_fwdb, e_fwdb);
    chk("model_wr_en", a_wr_en, e_wr_en);
    chk("model_wr_rd", a_wr_rd, e_wr_rd);
    chk("model_wr_sel", a_wr_sel, e_wr_sel);
    chk("model_long_busy", a_busy, e_busy);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic fsu, input logic ftu,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic p, input logic l, input logic fl, input logic sx);
    id_v = v; id_fs_use = fsu; id_ft_use = ftu; fs = s; ft = t; fd = d;
    id_pipe = p; id_long = l; flush = fl; stall_ext = sx;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int wcount;
    int kind;
    //            v fsu ftu fs ft fd p l fl sx | stall fwda fwdb wr_en wr_rd sel busy
    tbl[0]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1,  2, 3,  1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1,  5, 6,  4, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1,  4, 7, 10, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1,  4, 7, 10, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{1, 1, 1,  4, 7, 10, 1, 0, 0, 0,  0, 1, 0, 1, 4, 0, 0};
    tbl[6]  = '{1, 1, 1, 10, 10, 11, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0,  0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 1,  0, 0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 1,  0, 0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 1,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 1,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 1,  0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0, 0};
    tbl[16] = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    do_reset();

    // Table: reset/idle, RAW on the pipe, flush, stall_ext freeze, FPR 0.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].v, tbl[i].fsu, tbl[i].ftu, tbl[i].s, tbl[i].t, tbl[i].d,
             tbl[i].p, tbl[i].l, tbl[i].fl, tbl[i].sx);
      step();
      chk($sformatf("tbl%0d_stall", i), a_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_fwda", i), a_fwda, tbl[i].e_fwda);
      chk($sformatf("tbl%0d_fwdb", i), a_fwdb, tbl[i].e_fwdb);
      chk($sformatf("tbl%0d_wr_en", i), a_wr_en, tbl[i].e_wr_en);
      chk($sformatf("tbl%0d_wr_rd", i), a_wr_rd, tbl[i].e_wr_rd);
      chk($sformatf("tbl%0d_wr_sel", i), a_wr_sel, tbl[i].e_wr_sel);
      chk($sformatf("tbl%0d_long_busy", i), a_busy, tbl[i].e_busy);
      $display("vector %0d: stall=%0d fwda=%0d fwdb=%0d wr_en=%0d wr_rd=%0d wr_sel=%0d busy=%0d",
               i, a_stall, a_fwda, a_fwdb, a_wr_en, a_wr_rd, a_wr_sel, a_busy);
    end

    // Long pool full: fdiv f5, fsqrt f6, then fdiv f7 waits for f5 to retire.
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 0, 1, 0, 0); step();
    chk("full_f5_issue", a_stall, 0);
    set_in(1, 0, 0, 0, 0, 6, 0, 1, 0, 0); step();
    chk("full_f6_issue", a_stall, 0);
    set_in(1, 0, 0, 0, 0, 7, 0, 1, 0, 0);
    for (n = 0; n < 30; n++) begin
      step();
      if (!a_stall) break;
    end
    chk("full_release_delay", n, 10);
    chk("full_f5_wr_en", a_wr_en, 1);
    chk("full_f5_wr_rd", a_wr_rd, 5);
    chk("full_f5_wr_sel", a_wr_sel, 1);
    idle(); step();
    chk("full_f6_wr_rd", a_wr_rd, 6);
    chk("full_f6_wr_sel", a_wr_sel, 1);
    chk("full_busy_f7", a_busy, 1);
    for (int i = 0; i < 14; i++) step();
    $display("sequence long_full: released after %0d stalled cycles", n);

    // Port conflict: fadd f20 and fdiv f9 both ready in the same cycle.
    do_reset();
    set_in(1, 0, 0, 0, 0, 9, 0, 1, 0, 0); step();
    idle();
    for (int i = 0; i < 8; i++) step();
    set_in(1, 0, 0, 0, 0, 20, 1, 0, 0, 0); step();
    idle(); step(); step();
    set_in(1, 1, 0, 9, 0, 0, 0, 0, 0, 0); step();
    chk("conflict_dep_stall", a_stall, 1);
    chk("conflict_pipe_wr_rd", a_wr_rd, 20);
    chk("conflict_pipe_wr_sel", a_wr_sel, 0);
    step();
    chk("conflict_dep_release", a_stall, 0);
    chk("conflict_dep_fwda", a_fwda, 2);
    chk("conflict_long_wr_rd", a_wr_rd, 9);
    chk("conflict_long_wr_sel", a_wr_sel, 1);
    idle(); step(); step();
    $display("sequence port_conflict: pipe f20 then long f9");

    // WAW: fdiv f9 followed by fadd f9.
    do_reset();
    set_in(1, 0, 0, 0, 0, 9, 0, 1, 0, 0); step();
    set_in(1, 1, 1, 1, 2, 9, 1, 0, 0, 0);
    for (n = 0; n < 30; n++) begin
      step();
      if (!a_stall) break;
    end
`ifdef SCOREBOARD_WAW_EN
    chk("waw_stall_cycles", n, 11);
    chk("waw_release_wr_rd", a_wr_rd, 9);
`else
    chk("waw_stall_cycles", n, 0);
`endif
    idle();
    for (int i = 0; i < 14; i++) step();
    $display("sequence waw: fadd waited %0d cycles", n);

    // Reset while ops are in flight: nothing may be written afterwards.
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 4, 0, 1, 0, 0); step();
    idle(); clrn = 1'b0; step(); clrn = 1'b1;
    wcount = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (a_wr_en) wcount++;
    end
    chk("reset_discard_writes", wcount, 0);
    chk("reset_discard_busy", a_busy, 0);
    $display("sequence mid_reset: %0d writes after reset", wcount);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      kind = int'($urandom_range(0, 3));
      clrn = ($urandom_range(0, 499) != 0);
      stall_ext = ($urandom_range(0, 6) == 0);
      flush = !stall_ext && ($urandom_range(0, 11) == 0);
      id_v = ($urandom_range(0, 3) != 0);
      id_fs_use = $urandom_range(0, 1) != 0;
      id_ft_use = $urandom_range(0, 1) != 0;
      fs = 5'($urandom_range(0, 7));
      ft = 5'($urandom_range(0, 7));
      fd = 5'($urandom_range(0, 7));
      id_pipe = (kind == 0);
      id_long = (kind == 1);
      step();
    end
    clrn = 1'b1;
    $display("random phase: 3000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
